// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the ID-stage hazard controller: opcodes, IF/ID select
// encodings, controller states and counter width.
package hazard_ctrl_pkg;

    localparam int unsigned CNT_W = 16;
    localparam int unsigned OP_W  = 6;
    localparam int unsigned REG_W = 5;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

    typedef enum logic [1:0] {
        IFID_NORMAL = 2'b00,
        IFID_FLUSH  = 2'b01,
        IFID_HOLD   = 2'b10
    } ifid_sel_e;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_e;

    function automatic logic reads_rs(input logic [OP_W-1:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ);
    endfunction

    function automatic logic reads_rt(input logic [OP_W-1:0] op);
        return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter16.sv
// Saturating event counter: counts enabled cycles, sticks at all-ones.
module sat_counter16
    import hazard_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// ID-stage hazard controller: load-use stalls, branch/jump flushes and memory
// wait holds, with zero-latency controls into the IF/ID and ID/EX registers.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      IF_ID_IR,
    input  logic             BRANCH_TAKEN,
    input  logic             MEM_BUSY,
    output logic [1:0]       IF_ID_MUX,
    output logic             PC_WRITE,
    output logic             ID_EX_FLUSH,
    output logic             ID_EX_HOLD,
    output logic [CNT_W-1:0] STALL_CNT,
    output logic [CNT_W-1:0] FLUSH_CNT
);

    logic [OP_W-1:0]  opcode;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic             unused_ir_lo;

    assign opcode       = IF_ID_IR[31:26];
    assign rs           = IF_ID_IR[25:21];
    assign rt           = IF_ID_IR[20:16];
    assign unused_ir_lo = ^IF_ID_IR[15:0];

    state_e           state_q, state_d;
    logic             pend_flush_q, pend_flush_d;
    logic             ex_ld_v_q, ex_ld_v_d;
    logic [REG_W-1:0] ex_ld_rt_q, ex_ld_rt_d;

    ifid_sel_e if_id_mux_c;
    logic      pc_write_c;
    logic      id_ex_flush_c;
    logic      id_ex_hold_c;
    logic      load_use_c;
    logic      flush_pending_c;

    assign load_use_c = ex_ld_v_q &&
                        ((reads_rs(opcode) && (rs == ex_ld_rt_q)) ||
                         (reads_rt(opcode) && (rt == ex_ld_rt_q)));

    // A deferred flush can only have been recorded during a memory wait.
    assign flush_pending_c = pend_flush_q && (state_q == ST_MEM_WAIT);

    always_comb begin
        if_id_mux_c   = IFID_NORMAL;
        pc_write_c    = 1'b1;
        id_ex_flush_c = 1'b0;
        id_ex_hold_c  = 1'b0;
        state_d       = state_q;
        pend_flush_d  = pend_flush_q;
        ex_ld_v_d     = ex_ld_v_q;
        ex_ld_rt_d    = ex_ld_rt_q;

        if (MEM_BUSY) begin
            state_d      = ST_MEM_WAIT;
            if_id_mux_c  = IFID_HOLD;
            pc_write_c   = 1'b0;
            id_ex_hold_c = 1'b1;
            if (BRANCH_TAKEN) begin
                pend_flush_d = 1'b1;
            end
        end else begin
            state_d = ST_RUN;
            if (BRANCH_TAKEN || flush_pending_c) begin
                if_id_mux_c   = IFID_FLUSH;
                id_ex_flush_c = 1'b1;
                pend_flush_d  = 1'b0;
                ex_ld_v_d     = 1'b0;
            end else if (load_use_c) begin
                if_id_mux_c   = IFID_HOLD;
                pc_write_c    = 1'b0;
                id_ex_flush_c = 1'b1;
                ex_ld_v_d     = 1'b0;
            end else begin
                if ((opcode == OP_J) || (opcode == OP_JAL)) begin
                    if_id_mux_c = IFID_FLUSH;
                end
                // ID advances into EX: track whether it is a load with a live target.
                ex_ld_v_d  = (opcode == OP_LW) && (rt != '0);
                ex_ld_rt_d = rt;
            end
        end

        if (rst) begin
            if_id_mux_c   = IFID_NORMAL;
            pc_write_c    = 1'b0;
            id_ex_flush_c = 1'b1;
            id_ex_hold_c  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_RUN;
            pend_flush_q <= 1'b0;
            ex_ld_v_q    <= 1'b0;
            ex_ld_rt_q   <= '0;
        end else begin
            state_q      <= state_d;
            pend_flush_q <= pend_flush_d;
            ex_ld_v_q    <= ex_ld_v_d;
            ex_ld_rt_q   <= ex_ld_rt_d;
        end
    end

    sat_counter16 u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .en  (if_id_mux_c == IFID_HOLD),
        .clr (1'b0),
        .cnt (STALL_CNT)
    );

    sat_counter16 u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .en  (if_id_mux_c == IFID_FLUSH),
        .clr (1'b0),
        .cnt (FLUSH_CNT)
    );

    assign IF_ID_MUX   = if_id_mux_c;
    assign PC_WRITE    = pc_write_c;
    assign ID_EX_FLUSH = id_ex_flush_c;
    assign ID_EX_HOLD  = id_ex_hold_c;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: load-use, jumps, branch during memory wait,
// reset abort and counter saturation, with hand-computed expectations.
module tb_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] if_id_ir;
    logic        branch_taken;
    logic        mem_busy;
    logic [1:0]  if_id_mux;
    logic        pc_write;
    logic        id_ex_flush;
    logic        id_ex_hold;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // {IF_ID_MUX, PC_WRITE, ID_EX_FLUSH, ID_EX_HOLD}
    logic [4:0] outs;
    assign outs = {if_id_mux, pc_write, id_ex_flush, id_ex_hold};

    localparam logic [4:0] O_NORMAL = 5'b00_1_0_0;
    localparam logic [4:0] O_MEMHLD = 5'b10_0_0_1;
    localparam logic [4:0] O_LDUSE  = 5'b10_0_1_0;
    localparam logic [4:0] O_FLUSH  = 5'b01_1_1_0;
    localparam logic [4:0] O_JUMP   = 5'b01_1_0_0;
    localparam logic [4:0] O_RESET  = 5'b00_0_1_0;

    localparam logic [31:0] I_LW2  = 32'h8C02_0000;
    localparam logic [31:0] I_ADD  = 32'h0041_1820;
    localparam logic [31:0] I_LW0  = 32'h8C00_0000;
    localparam logic [31:0] I_ADD0 = 32'h0000_1820;
    localparam logic [31:0] I_LW5  = 32'h8C05_0000;
    localparam logic [31:0] I_SW5  = 32'hAC05_0000;
    localparam logic [31:0] I_BEQ5 = 32'h10A0_0000;
    localparam logic [31:0] I_J    = 32'h0800_0010;
    localparam logic [31:0] I_JAL  = 32'h0C00_0010;
    localparam logic [31:0] I_NOP  = 32'h0000_0000;

    hazard_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .IF_ID_IR     (if_id_ir),
        .BRANCH_TAKEN (branch_taken),
        .MEM_BUSY     (mem_busy),
        .IF_ID_MUX    (if_id_mux),
        .PC_WRITE     (pc_write),
        .ID_EX_FLUSH  (id_ex_flush),
        .ID_EX_HOLD   (id_ex_hold),
        .STALL_CNT    (stall_cnt),
        .FLUSH_CNT    (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of inputs at the falling edge; outputs settle #1 later.
    task automatic drive(input logic [31:0] ir, input logic br, input logic busy);
        @(negedge clk);
        if_id_ir     = ir;
        branch_taken = br;
        mem_busy     = busy;
        #1;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst          = 1'b1;
        if_id_ir     = I_NOP;
        branch_taken = 1'b0;
        mem_busy     = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; if_id_ir = I_LW2; branch_taken = 1'b1; mem_busy = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        n_cmp++; if (outs !== O_RESET) begin n_bad++; $display("FAIL reset_outs got %b want %b", outs, O_RESET); end
        n_cmp++; if (stall_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_stall got %0d want 0", stall_cnt); end
        n_cmp++; if (flush_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_flush got %0d want 0", flush_cnt); end
        do_reset();
    endtask

    task automatic test_load_use();
        do_reset();
        drive(I_LW2, 1'b0, 1'b0);
        n_cmp++; if (outs !== O_NORMAL) begin n_bad++; $display("FAIL lu_lw_adv got %b want %b", outs, O_NORMAL); end
        drive(I_ADD, 1'b0, 1'b0);
        n_cmp++; if (outs !== O_LDUSE) begin n_bad++; $display("FAIL lu_stall got %b want %b", outs, O_LDUSE); end
        after_edge();
        n_cmp++; if (stall_cnt !== 16'd1) begin n_bad++; $display("FAIL lu_stall_cnt got %0d want 1", stall_cnt); end
        drive(I_ADD, 1'b0, 1'b0);
        n_cmp++; if (outs !== O_NORMAL) begin n_bad++; $display("FAIL lu_release got %b want %b", outs, O_NORMAL); end
        after_edge();
        n_cmp++; if (stall_cnt !== 16'd1) begin n_bad++; $display("FAIL lu_once got %0d want 1", stall_cnt); end
    endtask

    task automatic test_lw_r0();
        do_reset();
        drive(I_LW0, 1'b0, 1'b0);
        drive(I_ADD0, 1'b0, 1'b0);
        n_cmp++; if (outs !== O_NORMAL) begin n_bad++; $display("FAIL r0_no_stall got %b want %b", outs, O_NORMAL); end
        after_edge();
        n_cmp++; if (stall_cnt !== 16'd0) begin n_bad++; $display("FAIL r0_stall_cnt got %0d want 0", stall_cnt); end
    endtask

    task automatic test_read_rules();
        do_reset();
        drive(I_LW5, 1'b0, 1'b0);
        drive(I_LW5, 1'b0, 1'b0);
        n_cmp++; if (outs !== O_NORMAL) begin n_bad++; $display("FAIL rr_lw_rt_not_read got %b want %b", outs, O_NORMAL); end
        drive(I_SW5, 1'b0, 1'b0);
        n_cmp++; if (outs !== O_LDUSE) begin n_bad++; $display("FAIL rr_sw_rt got %b want %b", outs, O_LDUSE); end
        drive(I_SW5, 1'b0, 1'b0);
        n_cmp++; if (outs !== O_NORMAL) begin n_bad++; $display("FAIL rr_sw_adv got %b want %b", outs, O_NORMAL); end
        drive(I_LW5, 1'b0, 1'b0);
        drive(I_BEQ5, 1'b0, 1'b0);
        n_cmp++; if (outs !== O_LDUSE) begin n_bad++; $display("FAIL rr_beq_rs got %b want %b", outs, O_LDUSE); end
        after_edge();
        n_cmp++; if (stall_cnt !== 16'd2) begin n_bad++; $display("FAIL rr_stall_cnt got %0d want 2", stall_cnt); end
    endtask

    task automatic test_jump();
        do_reset();
        drive(I_J, 1'b0, 1'b0);
        n_cmp++; if (outs !== O_JUMP) begin n_bad++; $display("FAIL j_flush got %b want %b", outs, O_JUMP); end
        after_edge();
        n_cmp++; if (flush_cnt !== 16'd1) begin n_bad++; $display("FAIL j_flush_cnt got %0d want 1", flush_cnt); end
        drive(I_NOP, 1'b0, 1'b0);
        n_cmp++; if (outs !== O_NORMAL) begin n_bad++; $display("FAIL j_one_cycle got %b want %b", outs, O_NORMAL); end
        drive(I_JAL, 1'b0, 1'b0);
        n_cmp++; if (outs !== O_JUMP) begin n_bad++; $display("FAIL jal_flush got %b want %b", outs, O_JUMP); end
        after_edge();
        n_cmp++; if (flush_cnt !== 16'd2) begin n_bad++; $display("FAIL jal_flush_cnt got %0d want 2", flush_cnt); end
        n_cmp++; if (stall_cnt !== 16'd0) begin n_bad++; $display("FAIL j_stall_cnt got %0d want 0", stall_cnt); end
    endtask

    task automatic test_mem_wait_branch();
        do_reset();
        drive(I_NOP, 1'b1, 1'b1);
        n_cmp++; if (outs !== O_MEMHLD) begin n_bad++; $display("FAIL mw_hold1 got %b want %b", outs, O_MEMHLD); end
        drive(I_NOP, 1'b0, 1'b1);
        n_cmp++; if (outs !== O_MEMHLD) begin n_bad++; $display("FAIL mw_hold2 got %b want %b", outs, O_MEMHLD); end
        drive(I_NOP, 1'b0, 1'b1);
        after_edge();
        n_cmp++; if (stall_cnt !== 16'd3) begin n_bad++; $display("FAIL mw_stall_cnt got %0d want 3", stall_cnt); end
        drive(I_NOP, 1'b0, 1'b0);
        n_cmp++; if (outs !== O_FLUSH) begin n_bad++; $display("FAIL mw_pend_flush got %b want %b", outs, O_FLUSH); end
        after_edge();
        n_cmp++; if (flush_cnt !== 16'd1) begin n_bad++; $display("FAIL mw_flush_cnt got %0d want 1", flush_cnt); end
        drive(I_NOP, 1'b0, 1'b0);
        n_cmp++; if (outs !== O_NORMAL) begin n_bad++; $display("FAIL mw_after got %b want %b", outs, O_NORMAL); end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        drive(I_NOP, 1'b1, 1'b1);
        drive(I_NOP, 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++; if (outs !== O_RESET) begin n_bad++; $display("FAIL rmw_outs got %b want %b", outs, O_RESET); end
        n_cmp++; if (stall_cnt !== 16'd0) begin n_bad++; $display("FAIL rmw_stall got %0d want 0", stall_cnt); end
        @(negedge clk);
        rst = 1'b0;
        mem_busy = 1'b0;
        #1;
        n_cmp++; if (outs !== O_NORMAL) begin n_bad++; $display("FAIL rmw_no_flush got %b want %b", outs, O_NORMAL); end
        after_edge();
        n_cmp++; if (flush_cnt !== 16'd0) begin n_bad++; $display("FAIL rmw_flush_cnt got %0d want 0", flush_cnt); end
    endtask

    task automatic test_branch_vs_load_use();
        do_reset();
        drive(I_LW2, 1'b0, 1'b0);
        drive(I_ADD, 1'b1, 1'b0);
        n_cmp++; if (outs !== O_FLUSH) begin n_bad++; $display("FAIL bl_flush_wins got %b want %b", outs, O_FLUSH); end
        after_edge();
        n_cmp++; if (stall_cnt !== 16'd0) begin n_bad++; $display("FAIL bl_stall_cnt got %0d want 0", stall_cnt); end
        n_cmp++; if (flush_cnt !== 16'd1) begin n_bad++; $display("FAIL bl_flush_cnt got %0d want 1", flush_cnt); end
        drive(I_ADD, 1'b0, 1'b0);
        n_cmp++; if (outs !== O_NORMAL) begin n_bad++; $display("FAIL bl_after got %b want %b", outs, O_NORMAL); end
    endtask

    task automatic test_hold_keeps_shadow();
        do_reset();
        drive(I_LW2, 1'b0, 1'b0);
        drive(I_ADD, 1'b0, 1'b1);
        n_cmp++; if (outs !== O_MEMHLD) begin n_bad++; $display("FAIL hs_hold got %b want %b", outs, O_MEMHLD); end
        drive(I_ADD, 1'b0, 1'b1);
        drive(I_ADD, 1'b0, 1'b0);
        n_cmp++; if (outs !== O_LDUSE) begin n_bad++; $display("FAIL hs_stall_after got %b want %b", outs, O_LDUSE); end
        after_edge();
        n_cmp++; if (stall_cnt !== 16'd3) begin n_bad++; $display("FAIL hs_stall_cnt got %0d want 3", stall_cnt); end
    endtask

    task automatic test_stall_saturate();
        do_reset();
        drive(I_NOP, 1'b0, 1'b1);
        for (int i = 0; i < 65534; i++) @(posedge clk);
        #1;
        n_cmp++; if (stall_cnt !== 16'hFFFE) begin n_bad++; $display("FAIL sat_fffe got %h want fffe", stall_cnt); end
        after_edge();
        n_cmp++; if (stall_cnt !== 16'hFFFF) begin n_bad++; $display("FAIL sat_ffff got %h want ffff", stall_cnt); end
        for (int i = 0; i < 5; i++) @(posedge clk);
        #1;
        n_cmp++; if (stall_cnt !== 16'hFFFF) begin n_bad++; $display("FAIL sat_nowrap got %h want ffff", stall_cnt); end
        drive(I_NOP, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_lw_r0();
        test_read_rules();
        test_jump();
        test_mem_wait_branch();
        test_reset_mid_wait();
        test_branch_vs_load_use();
        test_hold_keeps_shadow();
        test_stall_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
